cmd_stream_out: RTL and testbench
=================================

Name: cmd_stream_out

Overview:
Parametrised successor to the single-word command serializer. Streams the memory region [region_begin, region_end) to the SPI byte transmitter, one byte per write pulse. A prefetch word FIFO keeps SPI writes back-to-back while memory reads are in flight. Adds configurable word width, byte order, prefetch depth and abort, and handles empty regions.

Parameters:
ADDR_W, 16, memory word-address width
WORD_BYTES, 4, bytes per memory word (≥1)
FIFO_DEPTH, 4, prefetch word FIFO entries (power of 2, ≥2)
MSB_FIRST, 0, 0 = byte 0 (bits [7:0]) sent first; 1 = top byte sent first

Ports:
clk  in  1  clock
rst_L  in  1  reset
start  in  1  one-cycle pulse; begin streaming; ignored unless IDLE
abort  in  1  one-cycle pulse; cancel transfer
region_begin  in  ADDR_W  first word address, sampled on accepted start
region_end  in  ADDR_W  one past last word address, sampled on accepted start
mem_addr  out  ADDR_W  read address, valid with mem_rd_en
mem_rd_en  out  1  one-cycle read request
mem_rd_valid  in  1  read data valid (≥1 cycle after request)
mem_rd_data  in  8*WORD_BYTES  read data
busy  in  1  SPI transmitter busy
write  out  1  one-cycle byte strobe to SPI
byte_send  out  8  byte to send, valid with write
active  out  1  high while not IDLE
done  out  1  one-cycle pulse, region fully sent
aborted  out  1  one-cycle pulse, abort completed

Behaviour:
- Reset: rst_L is asynchronous and active-low; clk is the clock. Reset forces state IDLE, empties the FIFO, clears the outstanding flag, and drives every output to 0.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on start. Latch ptr = region_begin and end = region_end. Comparison is ptr != end with wrap modulo 2^ADDR_W. begin == end is an empty region.
- Prefetch in RUN: issue mem_rd_en with mem_addr = ptr, then ptr++, when ptr != end, no read is outstanding, and fifo_count < FIFO_DEPTH. At most one read is outstanding. FIFO_DEPTH counts occupied entries only; the outstanding read is not counted.
- On mem_rd_valid, push mem_rd_data into the FIFO and clear outstanding. A push into a full FIFO is impossible by construction; a bench assertion checks this.
- Serializer: when the shift register is empty and the FIFO is non-empty, pop a word into the shift register (same-cycle push and pop allowed). Byte index runs 0..WORD_BYTES-1.
- Each cycle with ~busy, ~write, and a loaded word: write=1 for exactly one cycle, byte_send = the selected byte, index++. Byte selection: MSB_FIRST=0 sends byte[index]; MSB_FIRST=1 sends byte[WORD_BYTES-1-index].
- Writes are therefore at most every 2nd cycle. byte_send holds its value until the next write.
- After the last byte is sent, the shift register frees. The next pop may occur in the same cycle the last write is issued.
- RUN -> IDLE when ptr == end, no outstanding read, FIFO empty, shift register empty, and write == 0. done=1 that cycle.
- Empty region: done pulses on the cycle after the start is accepted. No mem_rd_en, no write.
- Abort (any non-IDLE state): immediately flush the FIFO and shift register and stop issuing reads and writes. With a read outstanding, go to DRAIN, discard the pending mem_rd_valid, then go to IDLE with aborted=1. With no read outstanding, go to IDLE directly with aborted=1.
- done is never asserted for an aborted transfer.
- abort in IDLE is ignored.
- start in RUN or DRAIN is ignored.
- If start and abort arrive in the same IDLE cycle, abort is ignored and start is accepted.
- If abort arrives in the same cycle that done would fire, abort wins: aborted=1, done=0.
- Reset mid-transfer returns to IDLE silently; no done or aborted pulse.

Test Plan:
- WORD_BYTES=4, MSB_FIRST=0, region [0x10,0x12), words 0x44332211 and 0x88776655, busy=0 -> bytes 11 22 33 44 55 66 77 88, 8 write pulses, then done one cycle later; active=1 throughout the transfer.
- Same data with MSB_FIRST=1 -> bytes 44 33 22 11 88 77 66 55.
- Empty region, begin = end = 0x20 -> done on the cycle after start; zero mem_rd_en; zero write.
- Wrap: ADDR_W=4, region [0xE,0x1) -> reads issued at E, F, 0 in order; 12 bytes sent; done.
- Backpressure: busy held high for 50 cycles mid-stream, FIFO_DEPTH=4, 8-word region -> FIFO fills to exactly 4 words, reads stall, no bytes are lost or duplicated, and the byte stream stays in order after busy releases.
- Abort with a read outstanding (memory latency 3) -> no further write; DRAIN lasts until mem_rd_valid; aborted pulses; done stays 0. A following start then streams a new region correctly.

Source files
------------

// File: rtl/cmd_stream_out.sv
// cmd_stream_out: streams memory words [region_begin, region_end) to an SPI
// byte transmitter, one byte per write strobe, with a small prefetch FIFO so
// memory read latency does not stall the byte stream.
module cmd_stream_out #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_L,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [ADDR_W-1:0]       region_begin_i,
    input  logic [ADDR_W-1:0]       region_end_i,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic                    mem_rd_en_o,
    input  logic                    mem_rd_valid_i,
    input  logic [8*WORD_BYTES-1:0] mem_rd_data_i,
    input  logic                    busy_i,
    output logic                    write_o,
    output logic [7:0]              byte_send_o,
    output logic                    active_o,
    output logic                    done_o,
    output logic                    aborted_o
);

    localparam int unsigned WORD_W = 8 * WORD_BYTES;
    localparam int unsigned IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0]  end_q, end_d;
    logic               outst_q, outst_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WORD_W-1:0]  shift_q, shift_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               loaded_q, loaded_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               mem_rd_en_q, mem_rd_en_d;
    logic               write_q, write_d;
    logic [7:0]         byte_q, byte_d;
    logic               active_q, active_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;

    logic [WORD_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic               push;
    logic               pop;
    logic               send;
    logic [IDX_W-1:0]   sel_idx;
    logic [7:0]         cur_byte;

    // Byte lane selection for the word currently in the shift register.
    always_comb begin
        sel_idx  = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;
        cur_byte = shift_q[8*int'(sel_idx) +: 8];
    end

    // Next-state, prefetch, FIFO bookkeeping and serializer control.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        end_d       = end_q;
        outst_d     = outst_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        loaded_d    = loaded_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_en_d = 1'b0;
        write_d     = 1'b0;
        byte_d      = byte_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        send        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    ptr_d   = region_begin_i;
                    end_d   = region_end_i;
                end
            end

            RUN: begin
                if (abort_i) begin
                    // Flush everything; a read still in flight must be drained.
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                    loaded_d = 1'b0;
                    idx_d    = '0;
                    if (outst_q && !mem_rd_valid_i) begin
                        state_d = DRAIN;
                    end else begin
                        state_d   = IDLE;
                        outst_d   = 1'b0;
                        aborted_d = 1'b1;
                    end
                end else begin
                    push = outst_q && mem_rd_valid_i;
                    if (push) begin
                        outst_d  = 1'b0;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end

                    send = loaded_q && !busy_i && !write_q;
                    if (send) begin
                        write_d = 1'b1;
                        byte_d  = cur_byte;
                        if (idx_q == LAST_IDX) begin
                            loaded_d = 1'b0;
                            idx_d    = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end

                    // Refill the shift register, possibly in the cycle its last byte goes out.
                    pop = (count_q != '0) && (!loaded_q || (send && (idx_q == LAST_IDX)));
                    if (pop) begin
                        shift_d  = fifo_mem[rd_ptr_q];
                        loaded_d = 1'b1;
                        idx_d    = '0;
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end

                    if (push && !pop) begin
                        count_d = count_q + CNT_W'(1);
                    end else if (!push && pop) begin
                        count_d = count_q - CNT_W'(1);
                    end

                    if ((ptr_q != end_q) && !outst_q && (count_q < DEPTH_C)) begin
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = ptr_q;
                        ptr_d       = ptr_q + ADDR_W'(1);
                        outst_d     = 1'b1;
                    end

                    if ((ptr_q == end_q) && !outst_q && (count_q == '0) && !loaded_q && !write_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            DRAIN: begin
                if (mem_rd_valid_i) begin
                    state_d   = IDLE;
                    outst_d   = 1'b0;
                    aborted_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        active_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            end_q       <= '0;
            outst_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            shift_q     <= '0;
            idx_q       <= '0;
            loaded_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_en_q <= 1'b0;
            write_q     <= 1'b0;
            byte_q      <= '0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            end_q       <= end_d;
            outst_q     <= outst_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            loaded_q    <= loaded_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_en_q <= mem_rd_en_d;
            write_q     <= write_d;
            byte_q      <= byte_d;
            active_q    <= active_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    // Prefetch storage; occupancy is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_rd_data_i;
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_rd_en_o = mem_rd_en_q;
    assign write_o     = write_q;
    assign byte_send_o = byte_q;
    assign active_o    = active_q;
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;

endmodule

// File: tb/tb_cmd_stream_out.sv
// Bench for cmd_stream_out: two instances (16-bit address LSB-first, 4-bit
// address MSB-first) with a latency-programmable memory model and a byte /
// address scoreboard.
module tb_cmd_stream_out;

    localparam int unsigned WB    = 4;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        int unsigned u;
        logic [15:0] rb;
        logic [15:0] re;
        int unsigned lat;
        bit          with_abort;
        int unsigned exp_words;
    } vec_t;

    logic clk = 1'b0;
    logic rst_L;
    always #5 clk = ~clk;

    logic        start    [2];
    logic        abort    [2];
    logic        busy     [2];
    logic        rd_valid [2];
    logic        rd_en    [2];
    logic        write    [2];
    logic        active   [2];
    logic        done     [2];
    logic        aborted  [2];
    logic [31:0] rdata    [2];
    logic [7:0]  bsend    [2];
    logic [15:0] rb0, re0, addr0;
    logic [3:0]  rb1, re1, addr1;

    int n_chk  = 0;
    int n_fail = 0;
    int n_rd    [2];
    int n_wr    [2];
    int n_done  [2];
    int n_abt   [2];
    int n_inact [2];
    bit xfer_on [2];
    int lat     [2];
    bit pend    [2];
    int cnt     [2];
    logic [15:0] paddr [2];
    int max_cnt0;
    logic [15:0] mon_a;

    logic [7:0]  exp_q[$];
    logic [15:0] exp_addr_q[$];
    logic [7:0]  got_q[$];

    cmd_stream_out #(.ADDR_W(16), .WORD_BYTES(WB), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0)) u_dut0 (
        .clk(clk), .rst_L(rst_L), .start_i(start[0]), .abort_i(abort[0]),
        .region_begin_i(rb0), .region_end_i(re0),
        .mem_addr_o(addr0), .mem_rd_en_o(rd_en[0]), .mem_rd_valid_i(rd_valid[0]),
        .mem_rd_data_i(rdata[0]), .busy_i(busy[0]), .write_o(write[0]),
        .byte_send_o(bsend[0]), .active_o(active[0]), .done_o(done[0]), .aborted_o(aborted[0])
    );

    cmd_stream_out #(.ADDR_W(4), .WORD_BYTES(WB), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1)) u_dut1 (
        .clk(clk), .rst_L(rst_L), .start_i(start[1]), .abort_i(abort[1]),
        .region_begin_i(rb1), .region_end_i(re1),
        .mem_addr_o(addr1), .mem_rd_en_o(rd_en[1]), .mem_rd_valid_i(rd_valid[1]),
        .mem_rd_data_i(rdata[1]), .busy_i(busy[1]), .write_o(write[1]),
        .byte_send_o(bsend[1]), .active_o(active[1]), .done_o(done[1]), .aborted_o(aborted[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bad(input string name, input logic [31:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got 0x%0h, want none (t=%0t)", name, act, $time);
    endtask

    // Memory contents; instance 1 sees the same words offset by 0x10.
    function automatic logic [31:0] word_at(input int u, input logic [15:0] a);
        logic [15:0] m;
        m = (u == 0) ? a : (16'h0010 + {12'h000, a[3:0]});
        if (m == 16'h0010) return 32'h4433_2211;
        if (m == 16'h0011) return 32'h8877_6655;
        return {m[7:0] ^ 8'hA5, m[15:8] ^ 8'h3C, m[7:0] + 8'h01, m[7:0]};
    endfunction

    task automatic expect_word(input int u, input logic [15:0] a);
        logic [31:0] w;
        int k;
        w = word_at(u, a);
        for (int i = 0; i < int'(WB); i++) begin
            k = (u == 1) ? (int'(WB) - 1 - i) : i;
            exp_q.push_back(w[k*8 +: 8]);
        end
    endtask

    // Memory model and output monitor, evaluated away from the active edge.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            mon_a = (u == 0) ? addr0 : {12'h000, addr1};
            rd_valid[u] = 1'b0;
            if (pend[u]) begin
                if (cnt[u] <= 1) begin
                    rd_valid[u] = 1'b1;
                    rdata[u]    = word_at(u, paddr[u]);
                    pend[u]     = 1'b0;
                end else begin
                    cnt[u]--;
                end
            end
            if (rst_L && rd_en[u]) begin
                n_rd[u]++;
                if (exp_addr_q.size() == 0) bad("unexpected_read", 32'(mon_a));
                else chk("read_addr", 32'(mon_a), 32'(exp_addr_q.pop_front()));
                pend[u]  = 1'b1;
                cnt[u]   = lat[u];
                paddr[u] = mon_a;
            end
            if (rst_L && write[u]) begin
                n_wr[u]++;
                got_q.push_back(bsend[u]);
                if (exp_q.size() == 0) bad("unexpected_write", 32'(bsend[u]));
                else chk("byte_send", 32'(bsend[u]), 32'(exp_q.pop_front()));
            end
            if (done[u] || aborted[u]) begin
                if (done[u]) n_done[u]++;
                if (aborted[u]) n_abt[u]++;
                xfer_on[u] = 1'b0;
            end else if (xfer_on[u] && !active[u]) begin
                n_inact[u]++;
            end
        end
        if (rd_valid[0] && u_dut0.outst_q) chk("push_into_full_fifo0", 32'(u_dut0.count_q < 3'(DEPTH)), 32'd1);
        if (rd_valid[1] && u_dut1.outst_q) chk("push_into_full_fifo1", 32'(u_dut1.count_q < 3'(DEPTH)), 32'd1);
        if (32'(u_dut0.count_q) > max_cnt0) max_cnt0 = int'(u_dut0.count_q);
    end

    task automatic set_region(input int u, input logic [15:0] b, input logic [15:0] e);
        if (u == 0) begin rb0 = b; re0 = e; end
        else begin rb1 = b[3:0]; re1 = e[3:0]; end
    endtask

    task automatic queue_region(input int u, input logic [15:0] b, input logic [15:0] e, input bit with_bytes);
        logic [15:0] a, ee, mask;
        mask = (u == 0) ? 16'hFFFF : 16'h000F;
        a  = b & mask;
        ee = e & mask;
        while (a != ee) begin
            exp_addr_q.push_back(a);
            if (with_bytes) expect_word(u, a);
            a = (a + 16'd1) & mask;
        end
    endtask

    task automatic run(input vec_t v);
        int rd0, wr0, dn0, ab0, cyc;
        int u;
        u = int'(v.u);
        queue_region(u, v.rb, v.re, 1'b1);
        lat[u] = int'(v.lat);
        got_q.delete();
        rd0 = n_rd[u]; wr0 = n_wr[u]; dn0 = n_done[u]; ab0 = n_abt[u];
        n_inact[u] = 0;
        @(posedge clk); #1;
        start[u] = 1'b1;
        abort[u] = v.with_abort;
        set_region(u, v.rb, v.re);
        @(posedge clk); #1;
        start[u] = 1'b0;
        abort[u] = 1'b0;
        xfer_on[u] = 1'b1;
        chk("active_after_start", 32'(active[u]), 32'd1);
        cyc = 0;
        while (n_done[u] == dn0 && n_abt[u] == ab0 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk("done_count", 32'(n_done[u] - dn0), 32'd1);
        chk("aborted_count", 32'(n_abt[u] - ab0), 32'd0);
        chk("read_count", 32'(n_rd[u] - rd0), 32'(v.exp_words));
        chk("write_count", 32'(n_wr[u] - wr0), 32'(v.exp_words * WB));
        chk("bytes_left", 32'(exp_q.size()), 32'd0);
        chk("inactive_cycles", 32'(n_inact[u]), 32'd0);
        chk("active_after_done", 32'(active[u]), 32'd0);
    endtask

    logic [7:0] ref_lsb [8];
    logic [7:0] ref_msb [8];
    vec_t vecs [7];

    initial begin
        int rd0, wr0, dn0, ab0, rd1, wr1, cyc;
        rst_L = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; abort[u] = 1'b0; busy[u] = 1'b0; rd_valid[u] = 1'b0;
            rdata[u] = '0; n_rd[u] = 0; n_wr[u] = 0; n_done[u] = 0; n_abt[u] = 0;
            n_inact[u] = 0; xfer_on[u] = 1'b0; lat[u] = 1; pend[u] = 1'b0; cnt[u] = 0; paddr[u] = '0;
        end
        rb0 = '0; re0 = '0; rb1 = '0; re1 = '0; max_cnt0 = 0;
        ref_lsb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        ref_msb = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
        vecs[0] = '{0, 16'h0010, 16'h0012, 1, 1'b0, 2};
        vecs[1] = '{1, 16'h0000, 16'h0002, 1, 1'b0, 2};
        vecs[2] = '{0, 16'h0020, 16'h0020, 1, 1'b0, 0};
        vecs[3] = '{1, 16'h000E, 16'h0001, 2, 1'b0, 3};
        vecs[4] = '{0, 16'hFFFE, 16'h0003, 3, 1'b0, 5};
        vecs[5] = '{1, 16'h0003, 16'h0005, 1, 1'b1, 2};
        vecs[6] = '{0, 16'h0100, 16'h0107, 4, 1'b0, 7};

        // Reset state.
        #12;
        for (int u = 0; u < 2; u++) begin
            chk("rst_active", 32'(active[u]), 32'd0);
            chk("rst_write", 32'(write[u]), 32'd0);
            chk("rst_done", 32'(done[u]), 32'd0);
            chk("rst_rd_en", 32'(rd_en[u]), 32'd0);
        end
        chk("rst_aborted0", 32'(aborted[0]), 32'd0);
        @(posedge clk); #1;
        rst_L = 1'b1;
        repeat (2) @(posedge clk);

        // Empty region: done in the cycle following the RUN cycle, no traffic.
        rd0 = n_rd[0]; wr0 = n_wr[0];
        #1;
        start[0] = 1'b1; set_region(0, 16'h0020, 16'h0020);
        @(posedge clk); #1;
        start[0] = 1'b0;
        chk("empty_done_early", 32'(done[0]), 32'd0);
        chk("empty_active", 32'(active[0]), 32'd1);
        @(posedge clk); #1;
        chk("empty_done", 32'(done[0]), 32'd1);
        chk("empty_active_off", 32'(active[0]), 32'd0);
        @(posedge clk); #1;
        chk("empty_done_pulse", 32'(done[0]), 32'd0);
        chk("empty_reads", 32'(n_rd[0] - rd0), 32'd0);
        chk("empty_writes", 32'(n_wr[0] - wr0), 32'd0);

        // Backpressure: busy for 50 cycles after three bytes of an 8-word region.
        queue_region(0, 16'h0040, 16'h0048, 1'b1);
        lat[0] = 1;
        rd0 = n_rd[0]; wr0 = n_wr[0]; dn0 = n_done[0];
        start[0] = 1'b1; set_region(0, 16'h0040, 16'h0048);
        @(posedge clk); #1;
        start[0] = 1'b0;
        cyc = 0;
        while ((n_wr[0] - wr0) < 3 && cyc < 500) begin @(posedge clk); cyc++; end
        #1;
        busy[0] = 1'b1;
        max_cnt0 = 0;
        repeat (50) @(posedge clk);
        #1;
        chk("bp_fifo_max", 32'(max_cnt0), 32'(DEPTH));
        chk("bp_fifo_count", 32'(u_dut0.count_q), 32'(DEPTH));
        chk("bp_reads_stalled", 32'(n_rd[0] - rd0), 32'd5);
        chk("bp_writes_held", 32'(n_wr[0] - wr0), 32'd3);
        busy[0] = 1'b0;
        cyc = 0;
        while (n_done[0] == dn0 && cyc < 1000) begin @(posedge clk); cyc++; end
        #1;
        chk("bp_done", 32'(n_done[0] - dn0), 32'd1);
        chk("bp_reads", 32'(n_rd[0] - rd0), 32'd8);
        chk("bp_writes", 32'(n_wr[0] - wr0), 32'd32);
        chk("bp_bytes_left", 32'(exp_q.size()), 32'd0);

        // Abort with a read outstanding, memory latency 3.
        queue_region(0, 16'h0080, 16'h0088, 1'b1);
        lat[0] = 3;
        wr0 = n_wr[0]; dn0 = n_done[0]; ab0 = n_abt[0];
        @(posedge clk); #1;
        start[0] = 1'b1; set_region(0, 16'h0080, 16'h0088);
        @(posedge clk); #1;
        start[0] = 1'b0;
        cyc = 0;
        while ((n_wr[0] - wr0) < 2 && cyc < 500) begin @(posedge clk); #1; cyc++; end
        cyc = 0;
        while (!rd_en[0] && cyc < 200) begin @(posedge clk); #1; cyc++; end
        chk("abort_rd_seen", 32'(rd_en[0]), 32'd1);
        abort[0] = 1'b1;
        @(posedge clk); #1;
        abort[0] = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        wr1 = n_wr[0]; rd1 = n_rd[0];
        chk("drain_active", 32'(active[0]), 32'd1);
        chk("drain_aborted", 32'(aborted[0]), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("drain_wait_aborted", 32'(aborted[0]), 32'd0);
            chk("drain_wait_active", 32'(active[0]), 32'd1);
        end
        @(posedge clk); #1;
        chk("drain_aborted_pulse", 32'(aborted[0]), 32'd1);
        chk("drain_idle", 32'(active[0]), 32'd0);
        @(posedge clk); #1;
        chk("drain_aborted_once", 32'(aborted[0]), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_writes", 32'(n_wr[0] - wr1), 32'd0);
        chk("abort_no_reads", 32'(n_rd[0] - rd1), 32'd0);
        chk("abort_no_done", 32'(n_done[0] - dn0), 32'd0);
        chk("abort_count", 32'(n_abt[0] - ab0), 32'd1);

        // Table-driven transfers; the first one also follows the abort above.
        for (int i = 0; i < 7; i++) begin
            run(vecs[i]);
            if (i == 0) begin
                chk("lsb_len", 32'(got_q.size()), 32'd8);
                for (int k = 0; k < 8 && k < got_q.size(); k++) chk("lsb_order", 32'(got_q[k]), 32'(ref_lsb[k]));
            end
            if (i == 1) begin
                chk("msb_len", 32'(got_q.size()), 32'd8);
                for (int k = 0; k < 8 && k < got_q.size(); k++) chk("msb_order", 32'(got_q[k]), 32'(ref_msb[k]));
            end
        end

        // Abort with no read outstanding: busy holds all words locally.
        queue_region(1, 16'h0008, 16'h000C, 1'b0);
        lat[1] = 1;
        busy[1] = 1'b1;
        rd0 = n_rd[1]; wr0 = n_wr[1]; dn0 = n_done[1]; ab0 = n_abt[1];
        @(posedge clk); #1;
        start[1] = 1'b1; set_region(1, 16'h0008, 16'h000C);
        @(posedge clk); #1;
        start[1] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("nabort_reads", 32'(n_rd[1] - rd0), 32'd4);
        chk("nabort_outst", 32'(u_dut1.outst_q), 32'd0);
        abort[1] = 1'b1;
        @(posedge clk); #1;
        abort[1] = 1'b0;
        chk("nabort_aborted", 32'(aborted[1]), 32'd1);
        chk("nabort_idle", 32'(active[1]), 32'd0);
        busy[1] = 1'b0;
        @(posedge clk); #1;
        chk("nabort_pulse", 32'(aborted[1]), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("nabort_writes", 32'(n_wr[1] - wr0), 32'd0);
        chk("nabort_done", 32'(n_done[1] - dn0), 32'd0);

        // Abort in IDLE is ignored.
        ab0 = n_abt[1];
        abort[1] = 1'b1;
        @(posedge clk); #1;
        abort[1] = 1'b0;
        chk("idle_abort_active", 32'(active[1]), 32'd0);
        @(posedge clk); #1;
        chk("idle_abort_count", 32'(n_abt[1] - ab0), 32'd0);

        // Reset mid-transfer returns silently to IDLE.
        queue_region(0, 16'h0200, 16'h0210, 1'b1);
        lat[0] = 2;
        dn0 = n_done[0]; ab0 = n_abt[0];
        start[0] = 1'b1; set_region(0, 16'h0200, 16'h0210);
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_L = 1'b0;
        #1;
        chk("mid_rst_active", 32'(active[0]), 32'd0);
        chk("mid_rst_write", 32'(write[0]), 32'd0);
        @(posedge clk); #1;
        rst_L = 1'b1;
        exp_q.delete();
        exp_addr_q.delete();
        wr0 = n_wr[0];
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_no_done", 32'(n_done[0] - dn0), 32'd0);
        chk("mid_rst_no_aborted", 32'(n_abt[0] - ab0), 32'd0);
        chk("mid_rst_no_writes", 32'(n_wr[0] - wr0), 32'd0);
        chk("mid_rst_idle", 32'(active[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
